layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_sequencer.sv | 127 ++++++++++++
 tb/tb_layer_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Layer sequencer: steps a vector-scalar MAC through GROUPS x ACCUMULATIONS
// operand pairs fetched from weight/activation memories and hands out one result per group.
module layer_sequencer #(
  parameter int SIZE          = 6,
  parameter int WIDTH         = 8,
  parameter int ACCUMULATIONS = 3,
  parameter int GROUPS        = 4,
  parameter int ADDR_W        = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          err,
  output logic                                          wgt_rd_en,
  output logic [ADDR_W-1:0]                             wgt_addr,
  input  logic [SIZE*WIDTH-1:0]                         wgt_data,
  output logic                                          act_rd_en,
  output logic [ADDR_W-1:0]                             act_addr,
  input  logic [WIDTH-1:0]                              act_data,
  output logic                                          mac_clr,
  output logic                                          mac_en,
  output logic [SIZE*WIDTH-1:0]                         mac_a,
  output logic [WIDTH-1:0]                              mac_b,
  input  logic [SIZE*WIDTH-1:0]                         mac_out,
  input  logic                                          mac_done,
  output logic [SIZE*WIDTH-1:0]                         res_data,
  output logic [((GROUPS > 1) ? $clog2(GROUPS) : 1)-1:0] res_grp,
  output logic                                          res_valid,
  input  logic                                          res_ready
);

  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int KW = (ACCUMULATIONS > 1) ? $clog2(ACCUMULATIONS) : 1;

  typedef enum logic [3:0] {
    IDLE, CLEAR, FETCH, LOAD, MAC_A, MAC_B, SETTLE, OUT, FINISH
  } state_t;

  state_t                  state_reg, state_next;
  logic [GW-1:0]           g_reg;
  logic [KW-1:0]           k_reg;
  logic [SIZE*WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]        b_reg;
  logic [SIZE*WIDTH-1:0]   res_data_reg;
  logic [GW-1:0]           res_grp_reg;
  logic                    err_reg;

  logic last_pair;
  logic last_group;
  assign last_pair  = (k_reg == KW'(ACCUMULATIONS - 1));
  assign last_group = (g_reg == GW'(GROUPS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   state_next = FETCH;
      FETCH:   state_next = LOAD;
      LOAD:    state_next = MAC_A;
      MAC_A:   state_next = MAC_B;
      MAC_B:   state_next = last_pair ? SETTLE : FETCH;
      SETTLE:  state_next = OUT;
      OUT:     if (res_ready) state_next = last_group ? FINISH : CLEAR;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_reg != IDLE);
    done      = (state_reg == FINISH);
    mac_clr   = (state_reg == CLEAR);
    mac_en    = (state_reg == MAC_A) || (state_reg == MAC_B);
    wgt_rd_en = (state_reg == FETCH);
    act_rd_en = (state_reg == FETCH);
    res_valid = (state_reg == OUT);
    wgt_addr  = ADDR_W'(g_reg) * ADDR_W'(ACCUMULATIONS) + ADDR_W'(k_reg);
    act_addr  = ADDR_W'(k_reg);
  end

  // Counters, operand latches and the result/err registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g_reg        <= '0;
      k_reg        <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      res_data_reg <= '0;
      res_grp_reg  <= '0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          g_reg   <= '0;
          err_reg <= 1'b0;
        end
        CLEAR: k_reg <= '0;
        LOAD: begin
          a_reg <= wgt_data;
          b_reg <= act_data;
        end
        MAC_B: if (!last_pair) k_reg <= k_reg + KW'(1);
        SETTLE: begin
          res_data_reg <= mac_out;
          res_grp_reg  <= g_reg;
          if (!mac_done) err_reg <= 1'b1;
        end
        OUT: if (res_ready && !last_group) g_reg <= g_reg + GW'(1);
        default: ;
      endcase
    end
  end

  assign mac_a    = a_reg;
  assign mac_b    = b_reg;
  assign res_data = res_data_reg;
  assign res_grp  = res_grp_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: memory and vsmac models around the DUT, a table of
// directed layers with hand-computed group results, plus stall/start/reset/err sequences.
module tb_layer_sequencer;
  localparam int SIZE = 6, WIDTH = 8, ACC = 3, GROUPS = 4, ADDR_W = 8;
  localparam int EV_DONE = 0, EV_VALID = 1, EV_CLR = 2;

  logic clk = 1'b0;
  logic reset, start, res_ready, done_en;
  logic busy, done, err, wgt_rd_en, act_rd_en, mac_clr, mac_en, mac_done, res_valid;
  logic [ADDR_W-1:0] wgt_addr, act_addr;
  logic [SIZE*WIDTH-1:0] wgt_data, mac_a, mac_out, res_data;
  logic [WIDTH-1:0] act_data, mac_b;
  logic [1:0] res_grp;

  always #5 clk = ~clk;

  layer_sequencer #(.SIZE(SIZE), .WIDTH(WIDTH), .ACCUMULATIONS(ACC), .GROUPS(GROUPS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
    .wgt_rd_en(wgt_rd_en), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
    .act_rd_en(act_rd_en), .act_addr(act_addr), .act_data(act_data),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_out(mac_out), .mac_done(mac_done),
    .res_data(res_data), .res_grp(res_grp), .res_valid(res_valid), .res_ready(res_ready)
  );

  // Registered-read memories
  logic [SIZE*WIDTH-1:0] wmem [0:255];
  logic [WIDTH-1:0]      amem [0:255];
  always_ff @(posedge clk) begin
    if (wgt_rd_en) wgt_data <= wmem[wgt_addr];
    if (act_rd_en) act_data <= amem[act_addr];
  end

  // vsmac model: multiply on the first enable cycle of a pair, accumulate on the second
  logic [WIDTH-1:0]      prod [SIZE];
  logic [SIZE*WIDTH-1:0] acc;
  logic                  ph;
  int                    pairs;
  always_ff @(posedge clk or posedge reset) begin
    if (reset || mac_clr) begin
      acc <= '0; ph <= 1'b0; pairs <= 0;
      for (int l = 0; l < SIZE; l++) prod[l] <= '0;
    end else if (mac_en) begin
      if (!ph) begin
        for (int l = 0; l < SIZE; l++) prod[l] <= mac_a[l*WIDTH +: WIDTH] * mac_b;
      end else begin
        for (int l = 0; l < SIZE; l++) acc[l*WIDTH +: WIDTH] <= acc[l*WIDTH +: WIDTH] + prod[l];
        pairs <= pairs + 1;
      end
      ph <= ~ph;
    end
  end
  assign mac_out  = acc;
  assign mac_done = (pairs == ACC) && done_en;

  typedef struct packed {
    logic [7:0] a0, a1, a2;
    logic [7:0] wbase, wstep, lstep;
    logic [3:0][15:0] exp;   // lane 0 result per group
    logic [15:0] lane_step;  // added per lane index
  } vec_t;
  vec_t vecs [4];

  int checks = 0, errors = 0;
  int clr_cnt, en_cnt, since_clr, done_cnt, busy_after_done;
  bit prev_valid, prev_done;
  int lat_q[$], en_q[$], waddr_q[$], aaddr_q[$], grp_q[$];
  logic [SIZE*WIDTH-1:0] data_q[$];

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic clear_mon();
    clr_cnt = 0; en_cnt = 0; since_clr = 0; done_cnt = 0; busy_after_done = 1;
    lat_q.delete(); en_q.delete(); waddr_q.delete(); aaddr_q.delete();
    grp_q.delete(); data_q.delete();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mac_clr) begin clr_cnt++; en_cnt = 0; since_clr = 0; end
      else since_clr++;
      if (mac_en) en_cnt++;
      if (res_valid && !prev_valid) begin lat_q.push_back(since_clr); en_q.push_back(en_cnt); end
      if (wgt_rd_en) begin waddr_q.push_back(int'(wgt_addr)); aaddr_q.push_back(int'(act_addr)); end
      if (res_valid && res_ready) begin
        data_q.push_back(res_data); grp_q.push_back(int'(res_grp));
        $display("result grp=%0d data=%h", res_grp, res_data);
      end
      if (prev_done) busy_after_done = int'(busy);
      if (done) done_cnt++;
      prev_valid = res_valid; prev_done = done;
    end
  end

  task automatic wait_for(input int which, input int bound, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk);
      case (which)
        EV_DONE:  hit = done;
        EV_VALID: hit = res_valid;
        default:  hit = mac_clr;
      endcase
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s actual=timeout_after_%0d required=event", name, bound);
    end
  endtask

  task automatic start_pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic load_mem(input int idx);
    for (int a = 0; a < GROUPS*ACC; a++)
      for (int l = 0; l < SIZE; l++)
        wmem[a][l*WIDTH +: WIDTH] = 8'(int'(vecs[idx].wbase) + a*int'(vecs[idx].wstep) + l*int'(vecs[idx].lstep));
    amem[0] = vecs[idx].a0; amem[1] = vecs[idx].a1; amem[2] = vecs[idx].a2;
  endtask

  function automatic logic [SIZE*WIDTH-1:0] exp_word(input int idx, input int g);
    logic [SIZE*WIDTH-1:0] w;
    for (int l = 0; l < SIZE; l++)
      w[l*WIDTH +: WIDTH] = 8'(int'(vecs[idx].exp[g]) + l*int'(vecs[idx].lane_step));
    return w;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_strobes"}, {mac_en, mac_clr, wgt_rd_en, act_rd_en}, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_grp"}, res_grp, 0);
    chk({tag, "_mac_a"}, mac_a, 0);
    chk({tag, "_mac_b"}, mac_b, 0);
  endtask

  task automatic run_vec(input int idx);
    load_mem(idx);
    res_ready = 1'b1;
    clear_mon();
    start_pulse();
    wait_for(EV_DONE, 300, $sformatf("v%0d_done", idx));
    @(negedge clk); @(negedge clk); #1;
    $display("layer vec=%0d results=%0d fetches=%0d clears=%0d", idx, data_q.size(), waddr_q.size(), clr_cnt);
    chk($sformatf("v%0d_done_count", idx), done_cnt, 1);
    chk($sformatf("v%0d_busy_after_done", idx), busy_after_done, 0);
    chk($sformatf("v%0d_clr_pulses", idx), clr_cnt, GROUPS);
    chk($sformatf("v%0d_result_count", idx), data_q.size(), GROUPS);
    chk($sformatf("v%0d_fetch_count", idx), waddr_q.size(), GROUPS*ACC);
    for (int g = 0; g < GROUPS && g < data_q.size() && g < lat_q.size(); g++) begin
      chk($sformatf("v%0d_g%0d_grp", idx, g), grp_q[g], g);
      chk($sformatf("v%0d_g%0d_data", idx, g), data_q[g], exp_word(idx, g));
      chk($sformatf("v%0d_g%0d_latency", idx, g), lat_q[g], 2 + 4*ACC);
      chk($sformatf("v%0d_g%0d_en_cycles", idx, g), en_q[g], 2*ACC);
    end
    for (int i = 0; i < GROUPS*ACC && i < waddr_q.size(); i++) begin
      chk($sformatf("v%0d_wgt_addr%0d", idx, i), waddr_q[i], i);
      chk($sformatf("v%0d_act_addr%0d", idx, i), aaddr_q[i], i % ACC);
    end
  endtask

  logic [SIZE*WIDTH-1:0] snap;
  bit found;

  initial begin
    vecs[0] = '{a0:8'd2,  a1:8'd2,  a2:8'd2,  wbase:8'd1, wstep:8'd0, lstep:8'd0,
                exp:{16'd6, 16'd6, 16'd6, 16'd6}, lane_step:16'd0};
    vecs[1] = '{a0:8'd1,  a1:8'd2,  a2:8'd3,  wbase:8'd0, wstep:8'd1, lstep:8'd0,
                exp:{16'd62, 16'd44, 16'd26, 16'd8}, lane_step:16'd0};
    vecs[2] = '{a0:8'd3,  a1:8'd0,  a2:8'd5,  wbase:8'd2, wstep:8'd0, lstep:8'd1,
                exp:{16'd16, 16'd16, 16'd16, 16'd16}, lane_step:16'd8};
    vecs[3] = '{a0:8'd10, a1:8'd20, a2:8'd30, wbase:8'd4, wstep:8'd2, lstep:8'd0,
                exp:{16'd200, 16'd96, 16'd248, 16'd144}, lane_step:16'd0};

    reset = 1'b0; start = 1'b0; res_ready = 1'b0; done_en = 1'b1;
    clear_mon();
    #1 reset = 1'b1;
    #1 check_reset_outputs("por");
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;

    // res_ready without a pending result does nothing
    res_ready = 1'b1; clear_mon();
    repeat (5) @(negedge clk);
    #1 chk("idle_ready_busy", busy, 0);
    chk("idle_ready_no_clr", clr_cnt, 0);

    for (int v = 0; v < 4; v++) run_vec(v);

    // Downstream stall in OUT
    load_mem(0); res_ready = 1'b0; clear_mon();
    start_pulse();
    wait_for(EV_VALID, 100, "stall_first_valid");
    snap = res_data;
    chk("stall_first_data", snap, exp_word(0, 0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("stall_valid_c%0d", i), res_valid, 1);
      chk($sformatf("stall_data_c%0d", i), res_data, snap);
      chk($sformatf("stall_nofetch_c%0d", i), {wgt_rd_en, mac_en}, 0);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_release_clr", mac_clr, 1);
    chk("stall_release_valid", res_valid, 0);
    wait_for(EV_DONE, 300, "stall_done");
    @(negedge clk);

    // start held high for a whole layer
    load_mem(0); clear_mon();
    @(posedge clk); #1 start = 1'b1;
    wait_for(EV_DONE, 300, "hold_done");
    #1 chk("hold_single_layer_clrs", clr_cnt, GROUPS);
    @(negedge clk);
    chk("hold_idle_after_finish", busy, 0);
    @(negedge clk);
    chk("hold_restart_clr", mac_clr, 1);
    start = 1'b0;
    wait_for(EV_DONE, 300, "hold_second_done");
    @(negedge clk);

    // Reset in MAC_A of group 1
    load_mem(0); clear_mon();
    start_pulse();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      found = (clr_cnt == 2) && mac_en;
    end
    chk("midrst_reached_g1_mac_a", found, 1);
    reset = 1'b1;
    #1 check_reset_outputs("midrst");
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("midrst_no_done", done_cnt, 0);
    run_vec(0);

    // mac_done missing: err sticky until next start
    done_en = 1'b0; load_mem(0); clear_mon();
    start_pulse();
    wait_for(EV_VALID, 100, "err_first_valid");
    chk("err_after_settle", err, 1);
    chk("err_data_captured", res_data, exp_word(0, 0));
    wait_for(EV_DONE, 300, "err_done");
    @(negedge clk); @(negedge clk);
    chk("err_sticky_idle", err, 1);
    done_en = 1'b1;
    start_pulse();
    wait_for(EV_CLR, 10, "err_restart_clr");
    chk("err_cleared_on_start", err, 0);
    wait_for(EV_DONE, 300, "err_restart_done");
    chk("err_stays_clear", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
